// File: rtl/udp_pkg.sv
// ============================================================================
// Module      : udp_pkg
// Description : Shared constants and state type for the UDP receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package udp_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam int          HDR_WORDS     = 12;
    localparam logic [15:0] UDP_OVERHEAD  = 16'd14;
    localparam logic [15:0] UDP_MIN_LEN   = 16'd18;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PAY  = 3'd2,
        ST_DROP = 3'd3,
        ST_DONE = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/udp_rx_hdr_check.sv
// ============================================================================
// Module      : udp_rx_hdr_check
// Description : Combinational compare of one header word against local
//               MAC / IP / port, selected by header word index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_rx_hdr_check #(
    parameter bit ACCEPT_BCAST = 1'b1
) (
    input  logic [3:0]  hw,
    input  logic [31:0] rx_data,
    input  logic [47:0] mac,
    input  logic [31:0] ip_local,
    input  logic [15:0] port_local,
    output logic        match_ok,
    output logic        L_valid
);
    import udp_pkg::*;

    logic [31:0] w_mac_lo;
    logic [15:0] w_mac_hi;

    assign w_mac_lo = {mac[7:0], mac[15:8], mac[23:16], mac[31:24]};
    assign w_mac_hi = {mac[39:32], mac[47:40]};

    always_comb begin
        match_ok = 1'b1;
        case (hw)
            4'd0:    match_ok = (rx_data == w_mac_lo) ||
                                (ACCEPT_BCAST && (rx_data == 32'hFFFF_FFFF));
            4'd1:    match_ok = (rx_data[31:16] == w_mac_hi) ||
                                (ACCEPT_BCAST && (rx_data[31:16] == 16'hFFFF));
            4'd3:    match_ok = (rx_data == {ETH_TYPE_IPV4, IP_VER_IHL, 8'h00});
            4'd5:    match_ok = (rx_data[7:0] == IP_PROTO_UDP);
            4'd7:    match_ok = (rx_data[15:0] == ip_local[31:16]);
            4'd8:    match_ok = (rx_data[31:16] == ip_local[15:0]);
            4'd9:    match_ok = (rx_data[31:16] == port_local);
            default: match_ok = 1'b1;
        endcase
    end

    assign L_valid = (rx_data[15:0] >= UDP_MIN_LEN);

endmodule

`default_nettype wire

// File: rtl/udp_receiver.sv
// ============================================================================
// Module      : udp_receiver
// Description : Parses Ethernet/IPv4/UDP frames from the MAC RX stream,
//               filters by address/port and stores the payload in the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_receiver #(
    parameter int ADDR_W       = 11,
    parameter int MAX_WORDS    = 2048,
    parameter bit ACCEPT_BCAST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [31:0]       rx_data,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic [1:0]        rx_mod,
    input  logic              rx_dval,
    input  logic              rx_err,
    output logic              rx_rdy,
    input  logic [47:0]       mac,
    input  logic [31:0]       ip_local,
    input  logic [15:0]       port_local,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_adr_wr,
    output logic [31:0]       mem_wr_data,
    output logic [15:0]       rx_length,
    output logic [7:0]        rx_channel,
    output logic [31:0]       rx_time,
    output logic [31:0]       rx_crc,
    output logic [31:0]       rx_ip_source,
    output logic [15:0]       rx_port_source,
    output logic              END_RX,
    output logic              DROP_RX
);
    import udp_pkg::*;

    localparam logic [ADDR_W:0] c_MAX_WORDS = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [3:0]      c_LAST_HW   = 4'(HDR_WORDS - 1);

    rx_state_t         r_state;
    logic [3:0]        r_hw;
    logic [ADDR_W:0]   r_cnt;
    logic              r_ovf;
    logic [15:0]       r_len_udp;
    logic [31:0]       r_ip_src;
    logic [15:0]       r_port_src;
    logic [7:0]        r_chan;
    logic [31:0]       r_time;
    logic              r_rdy;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_wr_data;
    logic [15:0]       r_length;
    logic [7:0]        r_channel;
    logic [31:0]       r_time_out;
    logic [31:0]       r_crc;
    logic [31:0]       r_ip_out;
    logic [15:0]       r_port_out;
    logic              r_end;
    logic              r_drop;

    logic              w_acc;
    logic              w_active;
    logic [3:0]        w_chk_hw;
    logic              w_match_ok;
    logic              w_len_valid;
    logic              w_hdr_ok;
    logic [ADDR_W+2:0] w_bytes;
    logic [15:0]       w_pay_len;
    logic              w_room;
    logic              w_eop_ok;

    assign w_acc    = rx_dval & r_rdy & en;
    assign w_active = (r_state == ST_HDR) || (r_state == ST_PAY) || (r_state == ST_DROP);
    // A sop word always restarts parsing at header word 0
    assign w_chk_hw = rx_sop ? 4'd0 : r_hw;

    udp_rx_hdr_check #(
        .ACCEPT_BCAST (ACCEPT_BCAST)
    ) u_hdr_check (
        .hw         (w_chk_hw),
        .rx_data    (rx_data),
        .mac        (mac),
        .ip_local   (ip_local),
        .port_local (port_local),
        .match_ok   (w_match_ok),
        .L_valid    (w_len_valid)
    );

    assign w_hdr_ok  = w_match_ok & ((w_chk_hw != 4'd9) | w_len_valid);
    // Bytes carried by the written words plus the eop word, less its pad bytes
    assign w_bytes   = {r_cnt, 2'b00} + (ADDR_W+3)'(4) - (ADDR_W+3)'(rx_mod);
    assign w_pay_len = r_len_udp - UDP_OVERHEAD;
    assign w_room    = (r_cnt < c_MAX_WORDS);
    assign w_eop_ok  = !rx_err && !r_ovf && (32'(w_bytes) == 32'(w_pay_len));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hw       <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_len_udp  <= '0;
            r_ip_src   <= '0;
            r_port_src <= '0;
            r_chan     <= '0;
            r_time     <= '0;
            r_rdy      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_adr      <= '0;
            r_wr_data  <= '0;
            r_length   <= '0;
            r_channel  <= '0;
            r_time_out <= '0;
            r_crc      <= '0;
            r_ip_out   <= '0;
            r_port_out <= '0;
            r_end      <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_rdy   <= en;
            r_wr_en <= 1'b0;
            r_end   <= 1'b0;
            r_drop  <= 1'b0;
            if (!en && w_active) begin
                r_state <= ST_IDLE;
                r_drop  <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_state <= ST_IDLE;
            end else if (w_acc && rx_sop) begin
                // Aborts any frame in progress; sop+eop is a runt
                r_drop <= w_active | rx_eop;
                r_hw   <= 4'd1;
                if (rx_eop)
                    r_state <= ST_IDLE;
                else if (w_hdr_ok)
                    r_state <= ST_HDR;
                else
                    r_state <= ST_DROP;
            end else if (w_acc) begin
                case (r_state)
                    ST_HDR: begin
                        if (rx_eop) begin
                            r_state <= ST_IDLE;
                            r_drop  <= 1'b1;
                        end else if (!w_hdr_ok) begin
                            r_state <= ST_DROP;
                        end else begin
                            case (r_hw)
                                4'd6:    r_ip_src[31:16] <= rx_data[15:0];
                                4'd7:    r_ip_src[15:0]  <= rx_data[31:16];
                                4'd8:    r_port_src      <= rx_data[15:0];
                                4'd9:    r_len_udp       <= rx_data[15:0];
                                4'd10:   r_chan          <= rx_data[7:0];
                                4'd11:   r_time          <= rx_data;
                                default: ;
                            endcase
                            r_hw <= r_hw + 4'd1;
                            if (r_hw == c_LAST_HW) begin
                                r_state <= ST_PAY;
                                r_cnt   <= '0;
                                r_ovf   <= 1'b0;
                            end
                        end
                    end
                    ST_PAY: begin
                        if (rx_eop) begin
                            if (w_eop_ok) begin
                                r_state    <= ST_DONE;
                                r_end      <= 1'b1;
                                r_rdy      <= 1'b0;
                                r_length   <= w_pay_len;
                                r_crc      <= rx_data;
                                r_channel  <= r_chan;
                                r_time_out <= r_time;
                                r_ip_out   <= r_ip_src;
                                r_port_out <= r_port_src;
                            end else begin
                                r_state <= ST_IDLE;
                                r_drop  <= 1'b1;
                            end
                        end else if (w_room) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= rx_data;
                            r_adr     <= r_cnt[ADDR_W-1:0];
                            r_cnt     <= r_cnt + (ADDR_W+1)'(1);
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                    ST_DROP: begin
                        if (rx_eop) begin
                            r_state <= ST_IDLE;
                            r_drop  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_rdy         = r_rdy;
    assign mem_wr_en      = r_wr_en;
    assign mem_adr_wr     = r_adr;
    assign mem_wr_data    = r_wr_data;
    assign rx_length      = r_length;
    assign rx_channel     = r_channel;
    assign rx_time        = r_time_out;
    assign rx_crc         = r_crc;
    assign rx_ip_source   = r_ip_out;
    assign rx_port_source = r_port_out;
    assign END_RX         = r_end;
    assign DROP_RX        = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_udp_receiver.sv
// ============================================================================
// Module      : tb_udp_receiver
// Description : Self-checking bench for udp_receiver (table, directed and
//               randomized frames against a frame-level reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_udp_receiver;

    localparam int          AW   = 3;
    localparam int          MW   = 8;
    localparam logic [47:0] MAC  = 48'h6655_4433_2211;
    localparam logic [31:0] IPL  = 32'hC0A8_0001;
    localparam logic [15:0] PORT = 16'd1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [31:0]   rx_data = '0;
    logic          rx_sop = 1'b0, rx_eop = 1'b0, rx_dval = 1'b0, rx_err = 1'b0;
    logic [1:0]    rx_mod = '0;
    logic          rx_rdy, mem_wr_en, END_RX, DROP_RX;
    logic [AW-1:0] mem_adr_wr;
    logic [31:0]   mem_wr_data, rx_time, rx_crc, rx_ip_source;
    logic [15:0]   rx_length, rx_port_source;
    logic [7:0]    rx_channel;
    logic          nb_rdy, nb_wr_en, nb_end, nb_drop;
    logic [10:0]   nb_adr;
    logic [31:0]   nb_wr_data, nb_time, nb_crc, nb_ip;
    logic [15:0]   nb_len, nb_port;
    logic [7:0]    nb_chan;

    always #5 clk = ~clk;

    udp_receiver #(.ADDR_W(AW), .MAX_WORDS(MW), .ACCEPT_BCAST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rx_data(rx_data), .rx_sop(rx_sop),
        .rx_eop(rx_eop), .rx_mod(rx_mod), .rx_dval(rx_dval), .rx_err(rx_err),
        .rx_rdy(rx_rdy), .mac(MAC), .ip_local(IPL), .port_local(PORT),
        .mem_wr_en(mem_wr_en), .mem_adr_wr(mem_adr_wr), .mem_wr_data(mem_wr_data),
        .rx_length(rx_length), .rx_channel(rx_channel), .rx_time(rx_time),
        .rx_crc(rx_crc), .rx_ip_source(rx_ip_source), .rx_port_source(rx_port_source),
        .END_RX(END_RX), .DROP_RX(DROP_RX));

    udp_receiver #(.ADDR_W(11), .MAX_WORDS(2048), .ACCEPT_BCAST(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .en(en), .rx_data(rx_data), .rx_sop(rx_sop),
        .rx_eop(rx_eop), .rx_mod(rx_mod), .rx_dval(rx_dval), .rx_err(rx_err),
        .rx_rdy(nb_rdy), .mac(MAC), .ip_local(IPL), .port_local(PORT),
        .mem_wr_en(nb_wr_en), .mem_adr_wr(nb_adr), .mem_wr_data(nb_wr_data),
        .rx_length(nb_len), .rx_channel(nb_chan), .rx_time(nb_time),
        .rx_crc(nb_crc), .rx_ip_source(nb_ip), .rx_port_source(nb_port),
        .END_RX(nb_end), .DROP_RX(nb_drop));

    typedef struct {
        bit          bcast;
        logic [15:0] dport;
        logic [31:0] ipdst;
        logic [7:0]  proto;
        logic [15:0] L;
        int          npay;
        logic [1:0]  mod;
        bit          err;
        logic [7:0]  chan;
        logic [31:0] tstamp, srcip, crc, pbase;
        logic [15:0] sport;
    } fr_t;

    typedef struct {
        logic [31:0] d;
        bit          sop, eop, err;
        logic [1:0]  mod;
    } wd_t;

    typedef struct {
        string nm;
        fr_t   f;
        bit    exp_ok;
        bit    exp_ok_nb;
        int    exp_nwr;
    } vec_t;

    wd_t           txq[$];
    logic [31:0]   wr_d[$];
    logic [AW-1:0] wr_a[$];
    int n_pass = 0, n_tot = 0;
    int n_end, n_drop, n_end_nb, n_drop_nb;
    int negcnt = 0, eop_neg = 0, end_neg = 0, drop_neg = 0;
    logic [15:0] st_len = '0, st_port = '0;
    logic [7:0]  st_chan = '0;
    logic [31:0] st_time = '0, st_crc = '0, st_ip = '0;

    always @(negedge clk) begin
        negcnt++;
        if (rx_dval && rx_rdy && en && rx_eop) eop_neg = negcnt;
        if (END_RX)  begin n_end++;  end_neg = negcnt;  end
        if (DROP_RX) begin n_drop++; drop_neg = negcnt; end
        if (nb_end)  n_end_nb++;
        if (nb_drop) n_drop_nb++;
        if (mem_wr_en) begin
            wr_d.push_back(mem_wr_data);
            wr_a.push_back(mem_adr_wr);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clear();
        n_end = 0; n_drop = 0; n_end_nb = 0; n_drop_nb = 0;
        wr_d.delete(); wr_a.delete();
    endtask

    function automatic fr_t good_frame();
        fr_t f;
        f.bcast = 1'b0; f.dport = PORT; f.ipdst = IPL; f.proto = 8'h11;
        f.L = 16'd30; f.npay = 3; f.mod = 2'd0; f.err = 1'b0;
        f.chan = 8'h05; f.tstamp = 32'h1234_5678; f.srcip = 32'h0A00_0002;
        f.sport = 16'd5000; f.crc = 32'hDEAD_BEEF; f.pbase = 32'hA000_0001;
        return f;
    endfunction

    function automatic wd_t mk(input logic [31:0] d, input bit sop);
        wd_t w;
        w.d = d; w.sop = sop; w.eop = 1'b0; w.err = 1'b0; w.mod = 2'd0;
        return w;
    endfunction

    task automatic build(input fr_t f);
        wd_t w;
        txq.delete();
        txq.push_back(mk(f.bcast ? 32'hFFFF_FFFF : 32'h1122_3344, 1'b1));
        txq.push_back(mk({(f.bcast ? 16'hFFFF : 16'h5566), 16'hAAAA}, 1'b0));
        txq.push_back(mk(32'hBBCC_DDEE, 1'b0));
        txq.push_back(mk(32'h0800_4500, 1'b0));
        txq.push_back(mk({f.L + 16'd20, 16'h1234}, 1'b0));
        txq.push_back(mk({16'h4000, 8'h40, f.proto}, 1'b0));
        txq.push_back(mk({16'h0000, f.srcip[31:16]}, 1'b0));
        txq.push_back(mk({f.srcip[15:0], f.ipdst[31:16]}, 1'b0));
        txq.push_back(mk({f.ipdst[15:0], f.sport}, 1'b0));
        txq.push_back(mk({f.dport, f.L}, 1'b0));
        txq.push_back(mk({24'h0, f.chan}, 1'b0));
        txq.push_back(mk(f.tstamp, 1'b0));
        for (int i = 0; i < f.npay; i++) txq.push_back(mk(f.pbase + 32'(i), 1'b0));
        w = mk(f.crc, 1'b0);
        w.eop = 1'b1; w.mod = f.mod; w.err = f.err;
        txq.push_back(w);
    endtask

    task automatic drive_word(input wd_t w);
        bit ok = 1'b0;
        int k = 0;
        rx_data = w.d; rx_sop = w.sop; rx_eop = w.eop; rx_mod = w.mod; rx_err = w.err;
        rx_dval = 1'b1;
        while (!ok && k < 40) begin
            @(negedge clk);
            ok = rx_rdy;
            @(posedge clk);
            #1;
            k++;
        end
        if (!ok) chk("rdy_timeout", 64'(ok), 64'd1);
        rx_dval = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_mod = '0; rx_err = 1'b0;
    endtask

    task automatic send_range(input int a, input int b);
        for (int i = a; i < b; i++) drive_word(txq[i]);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame-level reference: accept iff every header rule holds and the
    // byte count implied by the eop word matches the UDP length
    task automatic predict(input fr_t f, input bit bc_ok, input int maxw,
                           output bit ok, output int nwr);
        bit hdr;
        int bytes;
        hdr = (!f.bcast || bc_ok) && f.dport == PORT && f.ipdst == IPL &&
              f.proto == 8'h11 && f.L >= 16'd18;
        bytes = 4 * (f.npay + 1) - int'(f.mod);
        nwr = hdr ? ((f.npay < maxw) ? f.npay : maxw) : 0;
        ok = hdr && !f.err && f.npay <= maxw && bytes == int'(f.L) - 14;
    endtask

    task automatic check_frame(input string nm, input fr_t f, input bit exp_ok,
                               input bit exp_ok_nb, input int exp_nwr);
        int n;
        chk({nm, " end_cnt"}, 64'(n_end), 64'(exp_ok));
        chk({nm, " drop_cnt"}, 64'(n_drop), 64'(!exp_ok));
        if (exp_ok) chk({nm, " end_lat"}, 64'(end_neg - eop_neg), 64'd1);
        else        chk({nm, " drop_lat"}, 64'(drop_neg - eop_neg), 64'd1);
        chk({nm, " nb_end"}, 64'(n_end_nb), 64'(exp_ok_nb));
        chk({nm, " nb_drop"}, 64'(n_drop_nb), 64'(!exp_ok_nb));
        chk({nm, " wr_cnt"}, 64'(wr_d.size()), 64'(exp_nwr));
        n = (wr_d.size() < exp_nwr) ? wr_d.size() : exp_nwr;
        for (int i = 0; i < n; i++) begin
            chk({nm, " wr_data"}, 64'(wr_d[i]), 64'(f.pbase + 32'(i)));
            chk({nm, " wr_addr"}, 64'(wr_a[i]), 64'(i % (1 << AW)));
        end
        if (exp_ok) begin
            st_len = f.L - 16'd14; st_crc = f.crc; st_chan = f.chan;
            st_time = f.tstamp; st_ip = f.srcip; st_port = f.sport;
        end
        chk({nm, " rx_length"}, 64'(rx_length), 64'(st_len));
        chk({nm, " rx_crc"}, 64'(rx_crc), 64'(st_crc));
        chk({nm, " rx_channel"}, 64'(rx_channel), 64'(st_chan));
        chk({nm, " rx_time"}, 64'(rx_time), 64'(st_time));
        chk({nm, " rx_ip_source"}, 64'(rx_ip_source), 64'(st_ip));
        chk({nm, " rx_port_source"}, 64'(rx_port_source), 64'(st_port));
    endtask

    task automatic run_frame(input string nm, input fr_t f, input bit exp_ok,
                             input bit exp_ok_nb, input int exp_nwr);
        clear();
        build(f);
        send_range(0, txq.size());
        gap(4);
        check_frame(nm, f, exp_ok, exp_ok_nb, exp_nwr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[12];
        fr_t f, fa;
        bit ok, ok_nb;
        int nwr, dummy;

        for (int i = 0; i < 12; i++) tbl[i].f = good_frame();
        tbl[0].nm  = "good";       tbl[0].exp_ok = 1; tbl[0].exp_ok_nb = 1; tbl[0].exp_nwr = 3;
        tbl[1].nm  = "port_miss";  tbl[1].f.dport = 16'd1001;
        tbl[1].exp_ok = 0; tbl[1].exp_ok_nb = 0; tbl[1].exp_nwr = 0;
        tbl[2].nm  = "bcast";      tbl[2].f.bcast = 1'b1;
        tbl[2].exp_ok = 1; tbl[2].exp_ok_nb = 0; tbl[2].exp_nwr = 3;
        tbl[3].nm  = "mac_err";    tbl[3].f.err = 1'b1;
        tbl[3].exp_ok = 0; tbl[3].exp_ok_nb = 0; tbl[3].exp_nwr = 3;
        tbl[4].nm  = "ip_miss";    tbl[4].f.ipdst = 32'hC0A8_0002;
        tbl[4].exp_ok = 0; tbl[4].exp_ok_nb = 0; tbl[4].exp_nwr = 0;
        tbl[5].nm  = "proto_tcp";  tbl[5].f.proto = 8'h06;
        tbl[5].exp_ok = 0; tbl[5].exp_ok_nb = 0; tbl[5].exp_nwr = 0;
        tbl[6].nm  = "len17";      tbl[6].f.L = 16'd17; tbl[6].f.npay = 0; tbl[6].f.mod = 2'd1;
        tbl[6].exp_ok = 0; tbl[6].exp_ok_nb = 0; tbl[6].exp_nwr = 0;
        tbl[7].nm  = "len_bad";    tbl[7].f.L = 16'd31;
        tbl[7].exp_ok = 0; tbl[7].exp_ok_nb = 0; tbl[7].exp_nwr = 3;
        tbl[8].nm  = "mod3";       tbl[8].f.L = 16'd23; tbl[8].f.npay = 2; tbl[8].f.mod = 2'd3;
        tbl[8].exp_ok = 1; tbl[8].exp_ok_nb = 1; tbl[8].exp_nwr = 2;
        tbl[9].nm  = "overflow";   tbl[9].f.L = 16'd54; tbl[9].f.npay = 9;
        tbl[9].exp_ok = 0; tbl[9].exp_ok_nb = 1; tbl[9].exp_nwr = 8;
        tbl[10].nm = "full";       tbl[10].f.L = 16'd50; tbl[10].f.npay = 8;
        tbl[10].exp_ok = 1; tbl[10].exp_ok_nb = 1; tbl[10].exp_nwr = 8;
        tbl[11].nm = "len18";      tbl[11].f.L = 16'd18; tbl[11].f.npay = 0;
        tbl[11].exp_ok = 1; tbl[11].exp_ok_nb = 1; tbl[11].exp_nwr = 0;

        en = 1'b1;
        clear();
        repeat (3) @(negedge clk);
        chk("reset rx_rdy", 64'(rx_rdy), 64'd0);
        chk("reset mem_wr_en", 64'(mem_wr_en), 64'd0);
        chk("reset pulses", 64'({END_RX, DROP_RX}), 64'd0);
        chk("reset status", 64'(rx_length | rx_crc | rx_time | rx_ip_source), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy after reset", 64'(rx_rdy), 64'd1);
        gap(2);

        for (int i = 0; i < 12; i++)
            run_frame(tbl[i].nm, tbl[i].f, tbl[i].exp_ok, tbl[i].exp_ok_nb, tbl[i].exp_nwr);

        // New sop at payload word 2 aborts the first frame
        clear();
        fa = good_frame();
        build(fa);
        send_range(0, 14);
        f = good_frame();
        f.pbase = 32'hB000_0001; f.crc = 32'h0BAD_F00D; f.chan = 8'h21;
        build(f);
        send_range(0, txq.size());
        gap(4);
        chk("abort drop_cnt", 64'(n_drop), 64'd1);
        chk("abort end_cnt", 64'(n_end), 64'd1);
        chk("abort nb_end", 64'(n_end_nb), 64'd1);
        chk("abort wr_cnt", 64'(wr_d.size()), 64'd5);
        if (wr_d.size() == 5) begin
            chk("abort first_a", 64'(wr_d[1]), 64'h0000_0000_A000_0002);
            chk("abort restart_addr", 64'(wr_a[2]), 64'd0);
            chk("abort restart_data", 64'(wr_d[2]), 64'h0000_0000_B000_0001);
            chk("abort last_addr", 64'(wr_a[4]), 64'd2);
        end
        st_len = f.L - 16'd14; st_crc = f.crc; st_chan = f.chan;
        st_time = f.tstamp; st_ip = f.srcip; st_port = f.sport;
        chk("abort rx_crc", 64'(rx_crc), 64'(st_crc));

        // en falling mid-header
        clear();
        build(good_frame());
        send_range(0, 6);
        en = 1'b0;
        gap(3);
        chk("en_low drop_cnt", 64'(n_drop), 64'd1);
        chk("en_low end_cnt", 64'(n_end), 64'd0);
        chk("en_low rx_rdy", 64'(rx_rdy), 64'd0);
        en = 1'b1;
        gap(2);
        chk("en_high rx_rdy", 64'(rx_rdy), 64'd1);

        // Reset asserted while header word 5 is on the bus
        clear();
        build(good_frame());
        send_range(0, 5);
        rx_data = txq[5].d; rx_dval = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst pulses", 64'(n_end + n_drop), 64'd0);
        chk("midrst rx_length", 64'(rx_length), 64'd0);
        chk("midrst rx_crc", 64'(rx_crc), 64'd0);
        chk("midrst rx_rdy", 64'(rx_rdy), 64'd0);
        rx_dval = 1'b0;
        rst_n = 1'b1;
        st_len = '0; st_crc = '0; st_chan = '0; st_time = '0; st_ip = '0; st_port = '0;
        gap(2);
        chk("midrst no_pulse", 64'(n_end + n_drop), 64'd0);
        f = good_frame();
        f.tstamp = 32'h0000_1111;
        run_frame("after_rst", f, 1'b1, 1'b1, 3);

        for (int t = 0; t < 40; t++) begin
            f = good_frame();
            f.npay   = int'($urandom_range(0, 10));
            f.mod    = 2'($urandom_range(0, 3));
            f.L      = ($urandom_range(0, 9) < 7) ? 16'(4 * (f.npay + 1) - int'(f.mod) + 14)
                                                  : 16'($urandom_range(10, 70));
            f.err    = ($urandom_range(0, 7) == 0);
            f.bcast  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) f.dport = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 9) == 0) f.ipdst = $urandom;
            if ($urandom_range(0, 9) == 0) f.proto = 8'($urandom_range(0, 255));
            f.chan   = 8'($urandom_range(0, 255));
            f.tstamp = $urandom; f.srcip = $urandom; f.crc = $urandom; f.pbase = $urandom;
            f.sport  = 16'($urandom_range(0, 65535));
            predict(f, 1'b1, MW, ok, nwr);
            predict(f, 1'b0, 2048, ok_nb, dummy);
            run_frame("rand", f, ok, ok_nb, nwr);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/udp_receiver.md
Name: udp_receiver

Overview:
- Receive-side counterpart of the UDP transmit path. Consumes 32-bit frames from the MAC RX streaming interface (sop/eop/mod/dval/err, 32-bit words).
- Parses the Ethernet, IPv4 and UDP headers and filters frames by local MAC, IP address and port.
- Writes the payload words into the receive buffer RAM. Reports channel, timestamp, trailing CRC word, source address, source port and length in a one-cycle completion strobe.
- Sits between the MAC RX FIFO and the receive buffer / control logic.

Parameters:
ADDR_W, 11, width of buffer write address
MAX_WORDS, 2048, buffer capacity in 32-bit words; payload beyond this drops the frame
ACCEPT_BCAST, 1, 1 = also accept destination MAC FF:FF:FF:FF:FF:FF

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  receive enable; 0 = deassert rx_rdy and drop any frame in progress
rx_data  in  32  frame word, first wire byte in [31:24]
rx_sop  in  1  start of packet
rx_eop  in  1  end of packet
rx_mod  in  2  invalid bytes in eop word
rx_dval  in  1  rx_data valid
rx_err  in  1  MAC error flag, sampled with eop
rx_rdy  out  1  block ready to accept a word
mac  in  48  local MAC, byte 0 in [7:0]
ip_local  in  32  local IP address
port_local  in  16  local UDP port
mem_wr_en  out  1  buffer write strobe
mem_adr_wr  out  ADDR_W  buffer write address
mem_wr_data  out  32  buffer write data
rx_length  out  16  payload bytes = UDP length − 14
rx_channel  out  8  channel byte
rx_time  out  32  timestamp word
rx_crc  out  32  trailing CRC word (eop word)
rx_ip_source  out  32  sender IP address
rx_port_source  out  16  sender UDP port
END_RX  out  1  one-cycle pulse: good frame stored
DROP_RX  out  1  one-cycle pulse: frame rejected

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-frame discards the frame with no pulse. After reset release, rx_rdy = en, registered, from the next clock.
- A word is accepted when rx_dval & rx_rdy. A header word counter hw (0..11) indexes the header words.
- States: IDLE, HDR, PAY, DROP, DONE.
- IDLE: accepted word with rx_sop → check word 0, hw ← 1, go to HDR. Words without sop are ignored.
- HDR header checks, by word index:
  - w0: must equal {mac[7:0],mac[15:8],mac[23:16],mac[31:24]}, or FFFFFFFF if ACCEPT_BCAST.
  - w1[31:16]: must equal {mac[39:32],mac[47:40]}, or FFFF if broadcast.
  - w3: must equal {16'h0800, 8'h45, 8'h00}.
  - w5[7:0]: must equal 8'h11.
  - w6[15:0] and w7[31:16]: captured into rx_ip_source.
  - w7[15:0] and w8[31:16]: must equal ip_local.
  - w8[15:0]: captured into rx_port_source.
  - w9[31:16]: must equal port_local. w9[15:0] is the UDP length L; L < 18 is a failure.
  - w10[7:0]: captured into rx_channel.
  - w11: captured into rx_time, then go to PAY.
  - Any failed check → DROP.
  - eop before w11 → DROP_RX pulse next cycle, then IDLE.
- PAY:
  - Each accepted non-eop word is written: mem_wr_en=1, mem_wr_data=word, registered (one-cycle latency). Address starts at 0 and increments per write.
  - The eop word is not written; it is captured into rx_crc.
  - At eop, success requires all of the following: rx_err=0; 4·(words written + 1) − rx_mod = L − 14; words written ≤ MAX_WORDS. If all hold → DONE; otherwise → DROP.
  - A write that would exceed MAX_WORDS is suppressed and the frame is flagged for drop.
- DONE:
  - One cycle with rx_rdy=0 and END_RX=1.
  - rx_length = L − 14.
  - Status outputs hold until the next END_RX.
  - Returns to IDLE.
- DROP:
  - Discards words until an accepted eop. DROP_RX pulses for one cycle the cycle after that eop (or immediately if already at eop), then IDLE.
  - Status outputs keep their previous good values. Buffer words already written are not rolled back.
- rx_sop while in HDR, PAY or DROP: the current frame is aborted with a DROP_RX pulse, and the sop word restarts parsing as w0 in the same cycle.
- en falling mid-frame: rx_rdy=0 next cycle, DROP_RX pulse, FSM to IDLE.
- Simultaneous rx_sop and rx_eop: treated as a runt → DROP_RX.
- Arithmetic: L − 14 uses 16-bit unsigned math, guarded by the L ≥ 18 check. The word counter is ADDR_W+1 bits wide so a full buffer is detectable.

Decomposition:
- Shared package udp_pkg:
  - constants ETH_TYPE_IPV4=16'h0800, IP_VER_IHL=8'h45, IP_PROTO_UDP=8'h11, HDR_WORDS=12, UDP_OVERHEAD=14
  - rx_state_t enum
- One sub-module, udp_rx_hdr_check: combinational per-word compare of (hw, rx_data) against mac/ip_local/port_local. Outputs match_ok and L_valid.

Test Plan:
- Good frame: MAC/IP/port matched, L=30, channel 8'h05, time 32'h12345678, payload 3 words A0000001..A0000003, eop word DEADBEEF with rx_mod=0 → writes at addresses 0–2 with correct data; END_RX pulses once; rx_length=16; rx_crc=DEADBEEF; rx_channel=05.
- Destination port mismatch (port_local=1000, frame port 1001) → zero buffer writes; DROP_RX pulses one cycle after eop; status outputs unchanged.
- Broadcast MAC with ACCEPT_BCAST=1 → END_RX. Same frame with ACCEPT_BCAST=0 → DROP_RX.
- rx_err=1 on the eop word of an otherwise good frame → DROP_RX; END_RX stays 0.
- New rx_sop at payload word 2, followed by a complete good frame → DROP_RX for the first frame, END_RX for the second; write address restarts at 0.
- rst_n low at header word 5, then a good frame → no pulse during reset; outputs 0; the following frame completes with END_RX.
